// File: rtl/nemu_stats_sink.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : nemu_stats_sink                                               |
// | Description : Network-emulator statistics sink: phased run control with     |
// |               windowed per-port packet counts and latency stats.            |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module nemu_stats_sink #(
    parameter int  PORTS     = 16,
    parameter int  TS_W      = 32,
    parameter int  CNT_W     = 32,
    parameter int  LAT_W     = 48,
    parameter int  DRAIN_MAX = 4096,
    localparam int ID_W      = $clog2(PORTS)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [TS_W-1:0]         i_timestamp,
    input  logic [PORTS-1:0]        i_rx_valid,
    input  logic [PORTS*ID_W-1:0]   i_rx_src,
    input  logic [PORTS*ID_W-1:0]   i_rx_dest,
    input  logic [PORTS*TS_W-1:0]   i_rx_stamp,
    input  logic [PORTS-1:0]        i_tx_valid,
    input  logic                    i_start,
    input  logic [31:0]             i_warmup_cycles,
    input  logic [31:0]             i_measure_cycles,
    input  logic                    i_rd_req,
    input  logic [ID_W-1:0]         i_rd_port,
    input  logic [2:0]              i_rd_sel,
    output logic                    o_rd_valid,
    output logic [LAT_W-1:0]        o_rd_data,
    output logic [2:0]              o_state,
    output logic                    o_done,
    output logic [CNT_W-1:0]        o_total_rx,
    output logic [CNT_W-1:0]        o_total_tx,
    output logic [PORTS-1:0]        o_dest_error,
    output logic                    o_overflow
);

    localparam int                SUM_W    = CNT_W + ID_W + 2;
    localparam logic [CNT_W-1:0]  CNT_ONES = {CNT_W{1'b1}};
    localparam logic [32:0]       DRAIN_LIM = 33'(DRAIN_MAX);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WARMUP  = 3'd1,
        S_MEASURE = 3'd2,
        S_DRAIN   = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t             state, state_nx;
    logic [31:0]        phase_cnt, warm_len, meas_len;
    logic [32:0]        cnt_inc;
    logic [TS_W-1:0]    t_start, t_end, win_now, win_end;
    logic               start_go;

    logic [PORTS-1:0][CNT_W-1:0] rx_cnt, rx_cnt_nx, tx_cnt, tx_cnt_nx;
    logic [PORTS-1:0][LAT_W-1:0] lat_sum, lat_sum_nx;
    logic [PORTS-1:0][TS_W-1:0]  lat_max, lat_max_nx, lat_min, lat_min_nx;
    logic [PORTS-1:0][TS_W-1:0]  lat;
    logic [PORTS-1:0][LAT_W:0]   sum_ext;
    logic [PORTS-1:0]            qual, tx_hit, dest_bad;

    logic [SUM_W-1:0]   rx_pop, tx_pop, rx_tot_sum, tx_tot_sum;
    logic [CNT_W-1:0]   total_rx_nx, total_tx_nx;
    logic               ovf_nx;
    logic [LAT_W-1:0]   rd_mux;
    logic               unused_src;

    // Source field carries no information the sink needs.
    assign unused_src = ^i_rx_src;

    assign start_go = i_start && (state == S_IDLE || state == S_DONE);
    assign cnt_inc  = {1'b0, phase_cnt} + 33'd1;
    assign win_now  = i_timestamp - t_start;
    assign win_end  = t_end - t_start;
    assign o_state  = state;
    assign o_done   = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // DRAIN exit looks at the registered totals, so a final rx closes the run one cycle later.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE, S_DONE: if (i_start) state_nx = S_WARMUP;
            S_WARMUP:       if (cnt_inc >= {1'b0, warm_len}) state_nx = S_MEASURE;
            S_MEASURE:      if (cnt_inc >= {1'b0, meas_len}) state_nx = S_DRAIN;
            S_DRAIN:        if (o_total_rx == o_total_tx || cnt_inc >= DRAIN_LIM) state_nx = S_DONE;
            default:        state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            phase_cnt <= '0;
            warm_len  <= '0;
            meas_len  <= '0;
            t_start   <= '0;
            t_end     <= '0;
        end else begin
            if (state_nx != state || state == S_IDLE || state == S_DONE) begin
                phase_cnt <= '0;
            end else begin
                phase_cnt <= phase_cnt + 32'd1;
            end
            if (start_go) begin
                warm_len <= i_warmup_cycles;
                meas_len <= i_measure_cycles;
                t_start  <= '0;
                t_end    <= '0;
            end
            if (state == S_WARMUP && state_nx == S_MEASURE) t_start <= i_timestamp;
            if (state == S_MEASURE && state_nx == S_DRAIN)  t_end   <= i_timestamp;
        end
    end

    // Window test is done on offsets from t_start so timestamp wrap is harmless.
    genvar k;
    generate
        for (k = 0; k < PORTS; k++) begin : g_port
            logic [TS_W-1:0] stamp, offs;
            logic [ID_W-1:0] dest;
            assign stamp       = i_rx_stamp[k*TS_W +: TS_W];
            assign dest        = i_rx_dest[k*ID_W +: ID_W];
            assign offs        = stamp - t_start;
            assign qual[k]     = i_rx_valid[k] &&
                                 ((state == S_MEASURE && offs <= win_now) ||
                                  (state == S_DRAIN   && offs <  win_end));
            assign tx_hit[k]   = i_tx_valid[k] && (state == S_MEASURE);
            assign dest_bad[k] = i_rx_valid[k] && (state != S_IDLE) && (dest != ID_W'(k));
            assign lat[k]      = i_timestamp - stamp;
            assign sum_ext[k]  = {1'b0, lat_sum[k]} + (LAT_W+1)'(lat[k]);
        end
    endgenerate

    always_comb begin
        rx_pop = '0;
        tx_pop = '0;
        for (int j = 0; j < PORTS; j++) begin
            rx_pop = rx_pop + SUM_W'(qual[j]);
            tx_pop = tx_pop + SUM_W'(tx_hit[j]);
        end
    end

    assign rx_tot_sum = SUM_W'(o_total_rx) + rx_pop;
    assign tx_tot_sum = SUM_W'(o_total_tx) + tx_pop;

    always_comb begin
        ovf_nx      = o_overflow;
        total_rx_nx = rx_tot_sum[CNT_W-1:0];
        total_tx_nx = tx_tot_sum[CNT_W-1:0];
        if (rx_tot_sum[SUM_W-1:CNT_W] != '0) begin
            total_rx_nx = CNT_ONES;
            ovf_nx      = 1'b1;
        end
        if (tx_tot_sum[SUM_W-1:CNT_W] != '0) begin
            total_tx_nx = CNT_ONES;
            ovf_nx      = 1'b1;
        end
        rx_cnt_nx  = rx_cnt;
        tx_cnt_nx  = tx_cnt;
        lat_sum_nx = lat_sum;
        lat_max_nx = lat_max;
        lat_min_nx = lat_min;
        for (int j = 0; j < PORTS; j++) begin
            if (tx_hit[j]) begin
                if (&tx_cnt[j]) ovf_nx = 1'b1;
                else            tx_cnt_nx[j] = tx_cnt[j] + 1'b1;
            end
            if (qual[j]) begin
                if (&rx_cnt[j]) ovf_nx = 1'b1;
                else            rx_cnt_nx[j] = rx_cnt[j] + 1'b1;
                if (sum_ext[j][LAT_W]) begin
                    lat_sum_nx[j] = '1;
                    ovf_nx        = 1'b1;
                end else begin
                    lat_sum_nx[j] = sum_ext[j][LAT_W-1:0];
                end
                if (lat[j] > lat_max[j]) lat_max_nx[j] = lat[j];
                if (lat[j] < lat_min[j]) lat_min_nx[j] = lat[j];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n || start_go) begin
            rx_cnt       <= '0;
            tx_cnt       <= '0;
            lat_sum      <= '0;
            lat_max      <= '0;
            lat_min      <= '1;
            o_total_rx   <= '0;
            o_total_tx   <= '0;
            o_dest_error <= '0;
            o_overflow   <= 1'b0;
        end else begin
            rx_cnt       <= rx_cnt_nx;
            tx_cnt       <= tx_cnt_nx;
            lat_sum      <= lat_sum_nx;
            lat_max      <= lat_max_nx;
            lat_min      <= lat_min_nx;
            o_total_rx   <= total_rx_nx;
            o_total_tx   <= total_tx_nx;
            o_dest_error <= o_dest_error | dest_bad;
            o_overflow   <= ovf_nx;
        end
    end

    always_comb begin
        rd_mux = '0;
        if ({1'b0, i_rd_port} < (ID_W+1)'(PORTS)) begin
            case (i_rd_sel)
                3'd0:    rd_mux = LAT_W'(rx_cnt[i_rd_port]);
                3'd1:    rd_mux = LAT_W'(tx_cnt[i_rd_port]);
                3'd2:    rd_mux = lat_sum[i_rd_port];
                3'd3:    rd_mux = LAT_W'(lat_max[i_rd_port]);
                3'd4:    rd_mux = LAT_W'(lat_min[i_rd_port]);
                default: rd_mux = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            o_rd_valid <= 1'b0;
            o_rd_data  <= '0;
        end else begin
            o_rd_valid <= i_rd_req;
            if (i_rd_req) o_rd_data <= rd_mux;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_nemu_stats_sink.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : tb_nemu_stats_sink                                            |
// | Description : Directed and randomized bench for nemu_stats_sink with a      |
// |               run-level reference model.                                    |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module tb_nemu_stats_sink;

    localparam int PORTS = 6;
    localparam int TS_W  = 16;
    localparam int CNT_W = 4;
    localparam int LAT_W = 24;
    localparam int DMAX  = 40;
    localparam int ID_W  = 3;
    localparam int CLIM  = 15;
    localparam longint LLIM = 64'd16777215;
    localparam int TMAX  = 65535;

    logic                  clk = 1'b0;
    logic                  reset_n;
    logic [TS_W-1:0]       ts;
    logic [PORTS-1:0]      rx_valid, tx_valid;
    logic [PORTS*ID_W-1:0] rx_src, rx_dest;
    logic [PORTS*TS_W-1:0] rx_stamp;
    logic                  start, rd_req;
    logic [31:0]           warm, meas;
    logic [ID_W-1:0]       rd_port;
    logic [2:0]            rd_sel;
    logic                  rd_valid, done, overflow;
    logic [LAT_W-1:0]      rd_data;
    logic [2:0]            state;
    logic [CNT_W-1:0]      total_rx, total_tx;
    logic [PORTS-1:0]      dest_error;

    int checks = 0;
    int failures = 0;

    // Reference model: run phase, cycles spent in phase, and per-port statistics.
    int     m_ph, m_n, m_wl, m_ml, m_tstart, m_tend, m_trx, m_ttx;
    int     m_rx[PORTS], m_tx[PORTS], m_max[PORTS], m_min[PORTS];
    longint m_sum[PORTS];
    bit [PORTS-1:0] m_derr;
    bit     m_ovf, m_rdv;
    longint m_rdd;

    nemu_stats_sink #(
        .PORTS(PORTS), .TS_W(TS_W), .CNT_W(CNT_W), .LAT_W(LAT_W), .DRAIN_MAX(DMAX)
    ) dut (
        .clk(clk), .reset_n(reset_n), .i_timestamp(ts),
        .i_rx_valid(rx_valid), .i_rx_src(rx_src), .i_rx_dest(rx_dest), .i_rx_stamp(rx_stamp),
        .i_tx_valid(tx_valid), .i_start(start),
        .i_warmup_cycles(warm), .i_measure_cycles(meas),
        .i_rd_req(rd_req), .i_rd_port(rd_port), .i_rd_sel(rd_sel),
        .o_rd_valid(rd_valid), .o_rd_data(rd_data), .o_state(state), .o_done(done),
        .o_total_rx(total_rx), .o_total_tx(total_tx), .o_dest_error(dest_error),
        .o_overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void model_clear();
        for (int k = 0; k < PORTS; k++) begin
            m_rx[k] = 0; m_tx[k] = 0; m_sum[k] = 0; m_max[k] = 0; m_min[k] = TMAX;
        end
        m_trx = 0; m_ttx = 0; m_derr = '0; m_ovf = 1'b0;
    endfunction

    function automatic int sat(input int v, input int a);
        if (v + a > CLIM) begin
            m_ovf = 1'b1;
            return CLIM;
        end
        return v + a;
    endfunction

    function automatic longint lookup(input int p, input int s);
        if (p >= PORTS) return 0;
        case (s)
            0: return longint'(m_rx[p]);
            1: return longint'(m_tx[p]);
            2: return m_sum[p];
            3: return longint'(m_max[p]);
            4: return longint'(m_min[p]);
            default: return 0;
        endcase
    endfunction

    // Apply the effect of the inputs currently driven at the coming clock edge.
    task automatic model_edge();
        bit leave;
        int now, stamp, pr, pt;
        if (!reset_n) begin
            model_clear();
            m_ph = 0; m_n = 0; m_tstart = 0; m_tend = 0; m_rdv = 1'b0; m_rdd = 0;
            return;
        end
        m_rdv = rd_req;
        if (rd_req) m_rdd = lookup(int'(rd_port), int'(rd_sel));
        if (start && (m_ph == 0 || m_ph == 4)) begin
            model_clear();
            m_ph = 1; m_n = 0; m_wl = int'(warm); m_ml = int'(meas); m_tstart = 0; m_tend = 0;
            return;
        end
        leave = 1'b0;
        case (m_ph)
            1: leave = (m_n + 1 >= ((m_wl == 0) ? 1 : m_wl));
            2: leave = (m_n + 1 >= ((m_ml == 0) ? 1 : m_ml));
            3: leave = (m_trx == m_ttx) || (m_n + 1 >= DMAX);
            default: leave = 1'b0;
        endcase
        now = int'(ts);
        pr = 0; pt = 0;
        for (int k = 0; k < PORTS; k++) begin
            stamp = int'(rx_stamp[k*TS_W +: TS_W]);
            if (m_ph != 0 && rx_valid[k] && int'(rx_dest[k*ID_W +: ID_W]) != k) m_derr[k] = 1'b1;
            if (m_ph == 2 && tx_valid[k]) begin
                pt++;
                m_tx[k] = sat(m_tx[k], 1);
            end
            if (rx_valid[k] && stamp >= m_tstart &&
                ((m_ph == 2 && stamp <= now) || (m_ph == 3 && stamp < m_tend))) begin
                pr++;
                m_rx[k] = sat(m_rx[k], 1);
                m_sum[k] = m_sum[k] + longint'(now - stamp);
                if (m_sum[k] > LLIM) begin m_sum[k] = LLIM; m_ovf = 1'b1; end
                if (now - stamp > m_max[k]) m_max[k] = now - stamp;
                if (now - stamp < m_min[k]) m_min[k] = now - stamp;
            end
        end
        m_trx = sat(m_trx, pr);
        m_ttx = sat(m_ttx, pt);
        if (leave) begin
            if (m_ph == 1) m_tstart = now;
            if (m_ph == 2) m_tend = now;
            m_ph++; m_n = 0;
        end else if (m_ph >= 1 && m_ph <= 3) begin
            m_n++;
        end
    endtask

    task automatic check_all();
        chk("state", 64'(state), 64'(m_ph));
        chk("done", 64'(done), 64'(m_ph == 4));
        chk("total_rx", 64'(total_rx), 64'(m_trx));
        chk("total_tx", 64'(total_tx), 64'(m_ttx));
        chk("dest_error", 64'(dest_error), 64'(m_derr));
        chk("overflow", 64'(overflow), 64'(m_ovf));
        chk("rd_valid", 64'(rd_valid), 64'(m_rdv));
        if (m_rdv) chk("rd_data", 64'(rd_data), 64'(m_rdd));
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        ts = ts + 16'd1;
        check_all();
        start = 1'b0; rd_req = 1'b0; rx_valid = '0; tx_valid = '0;
    endtask

    task automatic set_rx(input int k, input int dest, input int stamp);
        rx_valid[k] = 1'b1;
        rx_src[k*ID_W +: ID_W]   = ID_W'(k);
        rx_dest[k*ID_W +: ID_W]  = ID_W'(dest);
        rx_stamp[k*TS_W +: TS_W] = TS_W'(stamp);
    endtask

    task automatic read(input int p, input int s, output logic [63:0] d);
        rd_req = 1'b1; rd_port = ID_W'(p); rd_sel = 3'(s);
        step();
        d = 64'(rd_data);
    endtask

    task automatic run_start(input int w, input int m);
        start = 1'b1; warm = 32'(w); meas = 32'(m);
        step();
    endtask

    task automatic run_until(input int ph, input int lim);
        int n = 0;
        while (int'(state) != ph && n < lim) begin
            step();
            n++;
        end
        chk("reach_state", 64'(state), 64'(ph));
    endtask

    initial begin
        logic [63:0] d;
        int n, stamp0;
        reset_n = 1'b0; ts = 16'd1000; rx_valid = '0; tx_valid = '0; rx_src = '0; rx_dest = '0;
        rx_stamp = '0; start = 1'b0; warm = '0; meas = '0; rd_req = 1'b0; rd_port = '0; rd_sel = '0;
        model_clear();
        m_ph = 0; m_n = 0; m_tstart = 0; m_tend = 0; m_rdv = 1'b0; m_rdd = 0;

        // Reset state and reset values of the statistics.
        repeat (3) step();
        reset_n = 1'b1;
        read(2, 4, d); chk("lat_min_reset", d, 64'hFFFF);
        read(2, 3, d); chk("lat_max_reset", d, 64'd0);

        // Single packet 0->3 with 25-cycle latency.
        run_start(10, 100);
        run_until(2, 20);
        repeat (3) step();
        tx_valid[0] = 1'b1; stamp0 = int'(ts);
        step();
        repeat (24) step();
        set_rx(3, 3, stamp0);
        step();
        run_until(4, 200);
        read(3, 0, d); chk("rx_cnt3", d, 64'd1);
        read(3, 2, d); chk("lat_sum3", d, 64'd25);
        read(3, 3, d); chk("lat_max3", d, 64'd25);
        read(3, 4, d); chk("lat_min3", d, 64'd25);
        chk("done_flag", 64'(done), 64'd1);

        // Stamp earlier than the window start is ignored.
        run_start(0, 20);
        run_until(2, 5);
        set_rx(1, 1, m_tstart - 5);
        step();
        chk("early_stamp_total", 64'(total_rx), 64'd0);
        read(1, 0, d); chk("early_stamp_cnt", d, 64'd0);
        run_until(4, 80);

        // Every port receives in the same cycle.
        run_start(2, 30);
        run_until(2, 10);
        repeat (2) step();
        for (int k = 0; k < PORTS; k++) set_rx(k, k, m_tstart + 1);
        tx_valid = '1;
        step();
        chk("all_ports_rx", 64'(total_rx), 64'(PORTS));
        run_until(4, 100);

        // Missing packet: drain runs to its timeout.
        run_start(1, 10);
        run_until(2, 5);
        tx_valid = 6'b011111;
        step();
        for (int k = 0; k < 4; k++) begin set_rx(k, k, m_tstart + 1); step(); end
        run_until(3, 30);
        n = 0;
        while (int'(state) == 3 && n < 100) begin step(); n++; end
        chk("drain_timeout_len", 64'(n), 64'(DMAX));

        // Fifth packet arrives during drain: exit one cycle later.
        run_start(1, 10);
        run_until(2, 5);
        tx_valid = 6'b011111;
        step();
        for (int k = 0; k < 4; k++) begin set_rx(k, k, m_tstart + 1); step(); end
        run_until(3, 30);
        repeat (3) step();
        set_rx(4, 4, m_tstart + 2);
        step();
        chk("drain_after_fifth", 64'(state), 64'd3);
        chk("fifth_counted", 64'(total_rx), 64'd5);
        step();
        chk("done_after_fifth", 64'(state), 64'd4);

        // Misrouted packet sets a sticky flag cleared by the next start.
        run_start(0, 10);
        run_until(2, 5);
        set_rx(2, 5, m_tstart);
        step();
        chk("dest_err_set", 64'(dest_error[2]), 64'd1);
        run_until(4, 80);
        chk("dest_err_held", 64'(dest_error[2]), 64'd1);
        run_start(0, 5);
        chk("dest_err_cleared", 64'(dest_error[2]), 64'd0);
        run_until(4, 80);

        // Counter saturation, then reset mid-measure.
        run_start(0, 40);
        run_until(2, 5);
        for (int i = 0; i < 16; i++) begin set_rx(0, 0, m_tstart); step(); end
        read(0, 0, d); chk("rx_cnt_sat", d, 64'd15);
        chk("overflow_set", 64'(overflow), 64'd1);
        chk("mid_measure", 64'(state), 64'd2);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        chk("reset_idle", 64'(state), 64'd0);
        chk("reset_total_rx", 64'(total_rx), 64'd0);
        chk("reset_overflow", 64'(overflow), 64'd0);
        read(0, 0, d); chk("reset_rx_cnt", d, 64'd0);
        read(0, 4, d); chk("reset_lat_min", d, 64'hFFFF);

        // Randomized runs against the model.
        for (int r = 0; r < 6; r++) begin
            run_start(int'($urandom_range(0, 4)), int'($urandom_range(5, 30)));
            for (int c = 0; c < 150; c++) begin
                for (int k = 0; k < PORTS; k++) begin
                    tx_valid[k] = ($urandom_range(0, 99) < 30);
                    if ($urandom_range(0, 99) < 40)
                        set_rx(k, ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 7)) : k,
                               int'(ts) - int'($urandom_range(0, 40)));
                end
                rd_req = ($urandom_range(0, 1) == 1);
                rd_port = ID_W'($urandom_range(0, 7));
                rd_sel = 3'($urandom_range(0, 7));
                start = ($urandom_range(0, 99) < 3);
                step();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/nemu_stats_sink.md
NEMU_STATS_SINK -- requirements
Module: nemu_stats_sink

Interface
REQ-001 SHALL have parameter PORTS, default 16, number of network ports (2..64).
REQ-002 SHALL have parameter TS_W, default 32, timestamp width.
REQ-003 SHALL have parameter CNT_W, default 32, packet counter width.
REQ-004 SHALL have parameter LAT_W, default 48, latency accumulator width; derived ID_W = $clog2(PORTS).
REQ-005 SHALL have parameter DRAIN_MAX, default 4096, drain-phase timeout in cycles.
REQ-006 SHALL use one clock; reset is synchronous and active-low.
REQ-007 SHALL have port clk  input  1  clock, all logic on rising edge.
REQ-008 SHALL have port reset_n  input  1  synchronous active-low reset.
REQ-009 SHALL have port i_timestamp  input  TS_W  free-running network time.
REQ-010 SHALL have port i_rx_valid  input  PORTS  packet delivered at port k.
REQ-011 SHALL have port i_rx_src  input  PORTS*ID_W  source port of rx packet k.
REQ-012 SHALL have port i_rx_dest  input  PORTS*ID_W  destination field of rx packet k.
REQ-013 SHALL have port i_rx_stamp  input  PORTS*TS_W  injection timestamp carried by rx packet k.
REQ-014 SHALL have port i_tx_valid  input  PORTS  packet injected at port k.
REQ-015 SHALL have port i_start  input  1  run-start pulse.
REQ-016 SHALL have ports i_warmup_cycles, i_measure_cycles  input  32 each  phase lengths, sampled at start.
REQ-017 SHALL have ports i_rd_req  input  1, i_rd_port  input  ID_W, i_rd_sel  input  3  statistics read request.
REQ-018 SHALL have ports o_rd_valid  output  1, o_rd_data  output  LAT_W  read response.
REQ-019 SHALL have ports o_state  output  3, o_done  output  1, o_total_rx  output  CNT_W, o_total_tx  output  CNT_W, o_dest_error  output  PORTS, o_overflow  output  1.

Function
REQ-020 SHALL implement FSM IDLE(0), WARMUP(1), MEASURE(2), DRAIN(3), DONE(4), driven on o_state.
REQ-021 SHALL move IDLE or DONE -> WARMUP on i_start, clearing all statistics and latching phase lengths and cycle counter same edge; i_start ignored in other states.
REQ-022 SHALL leave WARMUP after i_warmup_cycles cycles (0 -> MEASURE next cycle), latching t_start = i_timestamp on entry to MEASURE.
REQ-023 SHALL leave MEASURE after i_measure_cycles cycles (0 -> DRAIN next cycle), latching t_end = i_timestamp on entry to DRAIN.
REQ-024 SHALL leave DRAIN for DONE when o_total_rx == o_total_tx or after DRAIN_MAX cycles, whichever first; o_done = 1 only in DONE.
REQ-025 SHALL count tx at port k (per-port tx_cnt[k], o_total_tx) only in MEASURE.
REQ-026 SHALL qualify rx at port k in MEASURE or DRAIN when t_start <= stamp < t_end (modulo-2^TS_W difference from t_start); unqualified rx ignored.
REQ-027 SHALL per qualified rx at port k: rx_cnt[k] += 1, lat_sum[k] += (i_timestamp - stamp) mod 2^TS_W, lat_max[k] = max, lat_min[k] = min.
REQ-028 SHALL set sticky o_dest_error[k] when valid rx at k (any state except IDLE) has i_rx_dest != k.
REQ-029 SHALL update o_total_rx/o_total_tx by popcount of qualified valids per cycle, all PORTS simultaneously.
REQ-030 SHALL saturate every counter/accumulator at all-ones, setting sticky o_overflow.
REQ-031 SHALL respond to i_rd_req with o_rd_valid high exactly one cycle later, o_rd_data zero-extended: sel 0 rx_cnt, 1 tx_cnt, 2 lat_sum, 3 lat_max, 4 lat_min, others 0.
REQ-032 SHALL return 0 for i_rd_port >= PORTS; reads legal in any state, returning values as of the request edge.
REQ-033 SHALL reset lat_min to all-ones; read with rx_cnt = 0 returns all-ones for sel 4.

Reset
REQ-034 SHALL, while reset_n = 0 at a clock edge, force IDLE, all counters/accumulators/lat_max 0, lat_min all-ones, o_rd_valid 0, o_done 0, o_dest_error 0, o_overflow 0, t_start/t_end 0.
REQ-035 SHALL abort any run on reset mid-operation, discarding partial statistics.

Verification
REQ-036 SHALL verify: warmup 10, measure 100, one packet port 0->3 stamped in window, rx 25 cycles later -> rx_cnt[3]=1, lat_sum[3]=25, lat_max=lat_min=25, DONE.
REQ-037 SHALL verify: rx with stamp before t_start during MEASURE -> no counter change, o_total_rx 0.
REQ-038 SHALL verify: all PORTS rx valid same cycle, qualified -> o_total_rx += PORTS in one cycle.
REQ-039 SHALL verify: tx 5, rx 4 -> DRAIN exits after DRAIN_MAX cycles; rx 5 -> exits cycle after fifth rx.
REQ-040 SHALL verify: rx at port 2 with dest 5 -> o_dest_error[2]=1 held until reset or next start.
REQ-041 SHALL verify: CNT_W=4, 16 qualified rx -> rx_cnt=15, o_overflow=1; reset_n low mid-MEASURE -> IDLE, all zero.
